// File: rtl/lc3_decode.sv
// LC-3 decode stage: waits on instruction memory, latches the word,
// splits it into fields and holds them until execute accepts.
module lc3_decode #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        decode_start,
  input  logic [15:0] pc_in,
  input  logic [15:0] instr_in,
  input  logic        exec_ready,
  output logic [15:0] ir,
  output logic [15:0] npc,
  output logic [3:0]  opCode,
  output logic [2:0]  dr,
  output logic [2:0]  sr1,
  output logic [2:0]  sr2,
  output logic        imm_mode,
  output logic [2:0]  br_nzp,
  output logic [15:0] offset,
  output logic        reg_we,
  output logic        illegal,
  output logic        decode_valid,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MEM,
    CAPTURE,
    VALID
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [1:0] cnt;
  logic       start_ok;

  assign start_ok = (state == IDLE) && decode_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (decode_start) state_nx = WAIT_MEM;
      WAIT_MEM: if (cnt == 2'd0)  state_nx = CAPTURE;
      CAPTURE:  state_nx = VALID;
      VALID:    if (exec_ready)   state_nx = IDLE;
    endcase
  end

  always_comb begin
    decode_valid = (state == VALID);
    busy         = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= 2'd0;
    else if (start_ok)
      cnt <= 2'(MEM_LATENCY - 1);
    else if (state == WAIT_MEM && cnt != 2'd0)
      cnt <= cnt - 2'd1;
  end

  // Field decode straight from memory data; registered at CAPTURE
  logic [3:0]  op;
  logic        is_br;
  logic        is_alu;
  logic        is_m9;
  logic        is_jsr;
  logic        is_m6;
  logic        is_trap;
  logic [15:0] off_d;
  logic        we_d;
  logic        ill_d;

  assign op      = instr_in[15:12];
  assign is_br   = (op == 4'b0000);
  assign is_alu  = (op == 4'b0001) || (op == 4'b0101);
  assign is_m9   = (op == 4'b0010) || (op == 4'b0011)
                || (op == 4'b1010) || (op == 4'b1011)
                || (op == 4'b1110);
  assign is_jsr  = (op == 4'b0100);
  assign is_m6   = (op == 4'b0110) || (op == 4'b0111);
  assign is_trap = (op == 4'b1111);

  always_comb begin
    off_d = 16'h0000;
    unique case (1'b1)
      is_br, is_m9:
        off_d = {{7{instr_in[8]}}, instr_in[8:0]};
      is_jsr:
        if (instr_in[11])
          off_d = {{5{instr_in[10]}}, instr_in[10:0]};
      is_m6:
        off_d = {{10{instr_in[5]}}, instr_in[5:0]};
      is_alu:
        if (instr_in[5])
          off_d = {{11{instr_in[4]}}, instr_in[4:0]};
      is_trap:
        off_d = {8'h00, instr_in[7:0]};
      default:
        off_d = 16'h0000;
    endcase
  end

  assign ill_d = (op == 4'b1101) || (op == 4'b1000);
  assign we_d  = is_alu || is_jsr
              || (op == 4'b1001) || (op == 4'b0010)
              || (op == 4'b1010) || (op == 4'b0110)
              || (op == 4'b1110);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      npc <= 16'h0000;
    else if (start_ok)
      npc <= pc_in + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir       <= 16'h0000;
      opCode   <= 4'h0;
      dr       <= 3'd0;
      sr1      <= 3'd0;
      sr2      <= 3'd0;
      imm_mode <= 1'b0;
      br_nzp   <= 3'd0;
      offset   <= 16'h0000;
      reg_we   <= 1'b0;
      illegal  <= 1'b0;
    end else if (state == CAPTURE) begin
      ir       <= instr_in;
      opCode   <= op;
      dr       <= instr_in[11:9];
      sr1      <= instr_in[8:6];
      sr2      <= instr_in[2:0];
      imm_mode <= is_alu & instr_in[5];
      br_nzp   <= is_br ? instr_in[11:9] : 3'd0;
      offset   <= off_d;
      reg_we   <= we_d;
      illegal  <= ill_d;
    end
  end

endmodule

// File: tb/tb_lc3_decode.sv
// Scoreboard bench for lc3_decode at MEM_LATENCY 1 and 3.
module tb_lc3_decode;

  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] npc;
    logic [3:0]  op;
    logic [2:0]  dr;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic        imm;
    logic [2:0]  nzp;
    logic [15:0] off;
    logic        we;
    logic        ill;
  } fields_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  start = 2'b00;
  logic [15:0] pc_in = 16'h0000;
  logic [15:0] instr_in = 16'h0000;
  logic        exec_ready = 1'b0;

  logic [15:0] ir [2];
  logic [15:0] npc [2];
  logic [3:0]  op [2];
  logic [2:0]  dr [2];
  logic [2:0]  sr1 [2];
  logic [2:0]  sr2 [2];
  logic        imm [2];
  logic [2:0]  nzp [2];
  logic [15:0] off [2];
  logic        we [2];
  logic        ill [2];
  logic        vld [2];
  logic        bsy [2];

  int checks = 0;
  int errors = 0;
  fields_t sb [$];

  always #5 clk = ~clk;

  lc3_decode #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .decode_start(start[0]),
    .pc_in(pc_in), .instr_in(instr_in),
    .exec_ready(exec_ready),
    .ir(ir[0]), .npc(npc[0]), .opCode(op[0]),
    .dr(dr[0]), .sr1(sr1[0]), .sr2(sr2[0]),
    .imm_mode(imm[0]), .br_nzp(nzp[0]),
    .offset(off[0]), .reg_we(we[0]),
    .illegal(ill[0]), .decode_valid(vld[0]),
    .busy(bsy[0])
  );

  lc3_decode #(.MEM_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst),
    .decode_start(start[1]),
    .pc_in(pc_in), .instr_in(instr_in),
    .exec_ready(exec_ready),
    .ir(ir[1]), .npc(npc[1]), .opCode(op[1]),
    .dr(dr[1]), .sr1(sr1[1]), .sr2(sr2[1]),
    .imm_mode(imm[1]), .br_nzp(nzp[1]),
    .offset(off[1]), .reg_we(we[1]),
    .illegal(ill[1]), .decode_valid(vld[1]),
    .busy(bsy[1])
  );

  function automatic fields_t model(
    input logic [15:0] pc,
    input logic [15:0] i
  );
    fields_t f;
    logic [15:0] s9, s6, s11, s5;
    s9  = {{7{i[8]}}, i[8:0]};
    s6  = {{10{i[5]}}, i[5:0]};
    s11 = {{5{i[10]}}, i[10:0]};
    s5  = {{11{i[4]}}, i[4:0]};
    f     = '0;
    f.ir  = i;
    f.npc = pc + 16'd1;
    f.op  = i[15:12];
    f.dr  = i[11:9];
    f.sr1 = i[8:6];
    f.sr2 = i[2:0];
    case (i[15:12])
      4'h0: begin f.nzp = i[11:9]; f.off = s9; end
      4'h1, 4'h5: begin
        f.imm = i[5];
        f.off = i[5] ? s5 : 16'h0;
        f.we  = 1'b1;
      end
      4'h2, 4'hA, 4'hE: begin f.off = s9; f.we = 1'b1; end
      4'h3, 4'hB: f.off = s9;
      4'h4: begin f.we = 1'b1; f.off = i[11] ? s11 : 16'h0; end
      4'h6: begin f.off = s6; f.we = 1'b1; end
      4'h7: f.off = s6;
      4'h9: f.we = 1'b1;
      4'hF: f.off = {8'h00, i[7:0]};
      4'h8, 4'hD: f.ill = 1'b1;
      default: ;
    endcase
    return f;
  endfunction

  function automatic fields_t snap(input int d);
    fields_t f;
    f.ir  = ir[d];
    f.npc = npc[d];
    f.op  = op[d];
    f.dr  = dr[d];
    f.sr1 = sr1[d];
    f.sr2 = sr2[d];
    f.imm = imm[d];
    f.nzp = nzp[d];
    f.off = off[d];
    f.we  = we[d];
    f.ill = ill[d];
    return f;
  endfunction

  task automatic pulse(input int d, input logic [15:0] pc,
                       input logic [15:0] ins);
    @(negedge clk);
    pc_in = pc;
    instr_in = ins;
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
  endtask

  task automatic wait_valid(input int d, inout int lat);
    while (vld[d] !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic pop_cmp(input int d, input string nm);
    fields_t e, g;
    g = snap(d);
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: output %h with empty scoreboard", nm, g);
    end else begin
      e = sb.pop_front();
      if (g !== e) begin
        errors++;
        $display("FAIL %s: got %h want %h", nm, g, e);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (snap(d) !== '0 || bsy[d] !== 1'b0 || vld[d] !== 1'b0) begin
          errors++;
          $display("FAIL reset%0d: fields %h busy %b valid %b want 0",
                   d, snap(d), bsy[d], vld[d]);
        end
      end
    end
  endtask

  task automatic test_add_imm;
    int lat = 0;
    exec_ready = 1'b1;
    sb.push_back(model(16'h3000, 16'h1261));
    pulse(0, 16'h3000, 16'h1261);
    wait_valid(0, lat);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL add_latency: got %0d want 2", lat);
    end
    pop_cmp(0, "add_fields");
    @(negedge clk);
    checks++;
    if (vld[0] !== 1'b0 || bsy[0] !== 1'b0) begin
      errors++;
      $display("FAIL add_pulse: valid %b busy %b want 0 0",
               vld[0], bsy[0]);
    end
  endtask

  task automatic test_br_stall;
    int lat = 0;
    fields_t held;
    exec_ready = 1'b0;
    sb.push_back(model(16'h3010, 16'h0FFE));
    pulse(0, 16'h3010, 16'h0FFE);
    wait_valid(0, lat);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL br_latency: got %0d want 2", lat);
    end
    checks++;
    if (nzp[0] !== 3'b111 || off[0] !== 16'hFFFE || we[0] !== 1'b0) begin
      errors++;
      $display("FAIL br_fields: nzp %b off %h we %b want 111 fffe 0",
               nzp[0], off[0], we[0]);
    end
    pop_cmp(0, "br_all");
    held = snap(0);
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (vld[0] !== 1'b1 || snap(0) !== held) begin
        errors++;
        $display("FAIL br_stall: valid %b fields %h want 1 %h",
                 vld[0], snap(0), held);
      end
    end
    exec_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (vld[0] !== 1'b0 || snap(0) !== held) begin
      errors++;
      $display("FAIL br_accept: valid %b fields %h want 0 %h",
               vld[0], snap(0), held);
    end
  endtask

  task automatic test_latency_wrap;
    int lat = 2;
    exec_ready = 1'b1;
    sb.push_back(model(16'hFFFF, 16'h6A3F));
    @(negedge clk);
    pc_in = 16'hFFFF;
    instr_in = 16'h6A3F;
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    @(negedge clk);
    pc_in = 16'h1234;
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    wait_valid(1, lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL l3_latency: got %0d want 4", lat);
    end
    checks++;
    if (npc[1] !== 16'h0000 || off[1] !== 16'hFFFF
        || dr[1] !== 3'd5 || sr1[1] !== 3'd0) begin
      errors++;
      $display("FAIL l3_fields: npc %h off %h dr %0d sr1 %0d",
               npc[1], off[1], dr[1], sr1[1]);
    end
    pop_cmp(1, "l3_all");
    @(negedge clk);
    checks++;
    if (vld[1] !== 1'b0 || bsy[1] !== 1'b0) begin
      errors++;
      $display("FAIL l3_done: valid %b busy %b want 0 0",
               vld[1], bsy[1]);
    end
  endtask

  task automatic test_illegal_trap;
    int lat;
    exec_ready = 1'b1;
    lat = 0;
    sb.push_back(model(16'h3020, 16'hD000));
    pulse(0, 16'h3020, 16'hD000);
    wait_valid(0, lat);
    checks++;
    if (ill[0] !== 1'b1 || we[0] !== 1'b0 || lat !== 2) begin
      errors++;
      $display("FAIL illegal: ill %b we %b lat %0d want 1 0 2",
               ill[0], we[0], lat);
    end
    pop_cmp(0, "illegal_all");
    lat = 0;
    sb.push_back(model(16'h3021, 16'hF025));
    pulse(0, 16'h3021, 16'hF025);
    wait_valid(0, lat);
    checks++;
    if (off[0] !== 16'h0025 || ill[0] !== 1'b0 || lat !== 2) begin
      errors++;
      $display("FAIL trap: off %h ill %b lat %0d want 0025 0 2",
               off[0], ill[0], lat);
    end
    pop_cmp(0, "trap_all");
  endtask

  task automatic test_reset_mid;
    int lat = 0;
    exec_ready = 1'b1;
    pulse(0, 16'h4000, 16'h1261);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (snap(0) !== '0 || bsy[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: fields %h busy %b want 0 0",
               snap(0), bsy[0]);
    end
    repeat (6) begin
      @(negedge clk);
      checks++;
      if (vld[0] !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_valid: got %b want 0", vld[0]);
      end
    end
    sb.push_back(model(16'h4100, 16'h5A82));
    pulse(0, 16'h4100, 16'h5A82);
    wait_valid(0, lat);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL rst_next_latency: got %0d want 2", lat);
    end
    pop_cmp(0, "rst_next_all");
  endtask

  task automatic test_back_to_back;
    logic [15:0] tbl [12];
    int lat;
    tbl = '{16'h2205, 16'h4FFF, 16'h4080, 16'h3C81,
            16'h7E7F, 16'h967F, 16'hA3F0, 16'hB610,
            16'hC1C0, 16'hE9FF, 16'h8000, 16'h5B3F};
    exec_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      lat = 0;
      sb.push_back(model(16'h0100 + 16'(i), tbl[i]));
      pulse(0, 16'h0100 + 16'(i), tbl[i]);
      wait_valid(0, lat);
      checks++;
      if (lat !== 2) begin
        errors++;
        $display("FAIL b2b_latency%0d: got %0d want 2", i, lat);
      end
      pop_cmp(0, "b2b_fields");
    end
    @(negedge clk);
    checks++;
    if (sb.size() !== 0 || vld[0] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: queue %0d valid %b want 0 0",
               sb.size(), vld[0]);
    end
  endtask

  initial begin
    test_reset;
    test_add_imm;
    test_br_stall;
    test_latency_wrap;
    test_illegal_trap;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
